routelookup_arb: RTL and testbench

Shares the routing table's single destination-lookup port among NETH transmit-side requesters, one per Ethernet port. Each requester presents a destination MAC. The block grants requesters round-robin and issues one lookup at a time to the table. It then captures the returned port mask, removes the requester's own port, and returns the mask to that requester over a handshaked response channel. It sits between the per-port TX packet front ends and the routing table's TX lookup interface.

---
 rtl/routelookup_arb.sv | 148 ++++++++++++++
 tb/tb_routelookup_arb.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/routelookup_arb.sv
// routelookup_arb
//   Shares the routing table's single TX destination-lookup port among NETH
//   per-port requesters. Requests are granted round-robin. One lookup is in
//   flight at a time. The returned port mask can have the requester's own port
//   removed, and it goes back to that requester over a valid/ready response
//   channel.
//
// Ports
//   i_clk, i_reset  clock; synchronous active-high reset
//   S_VALID/S_READY per-requester lookup request handshake (S_READY <= one-hot)
//   S_DSTMAC        packed destination MACs, requester k at [k*MACW +: MACW]
//   RESP_VALID      response valid, one-hot to the granted requester
//   RESP_READY      response accepted (only the granted bit is honoured)
//   RESP_PORT       destination port mask, shared by all requesters
//   TBL_VALID/READY lookup request handshake towards the routing table
//   TBL_DSTMAC      MAC being looked up
//   TBL_PORT        table result, valid one cycle after the TBL handshake
module routelookup_arb #(
    parameter int unsigned NETH         = 4,
    parameter int unsigned MACW         = 48,
    parameter bit          OPT_NOSELF   = 1'b1,
    parameter bit          OPT_LOWPOWER = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NETH-1:0]      S_VALID,
    output logic [NETH-1:0]      S_READY,
    input  logic [NETH*MACW-1:0] S_DSTMAC,
    output logic [NETH-1:0]      RESP_VALID,
    input  logic [NETH-1:0]      RESP_READY,
    output logic [NETH-1:0]      RESP_PORT,
    output logic                 TBL_VALID,
    input  logic                 TBL_READY,
    output logic [MACW-1:0]      TBL_DSTMAC,
    input  logic [NETH-1:0]      TBL_PORT
);

    localparam int unsigned LW = (NETH > 1) ? $clog2(NETH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]      state_q,  state_d;
    logic [NETH-1:0] grant_q,  grant_d;
    logic [LW-1:0]   last_q,   last_d;
    logic [MACW-1:0] mac_q,    mac_d;
    logic [NETH-1:0] result_q, result_d;

    logic            sel_found;
    logic [NETH-1:0] sel_oh;
    logic [LW-1:0]   sel_idx;
    logic [MACW-1:0] sel_mac;
    logic [31:0]     cand;

    logic tbl_active;
    logic resp_active;
    logic resp_done;

    // Round-robin search starting just after the previous grant. The wrap is
    // explicit so NETH need not be a power of two. The inner loop has constant
    // indices, which keeps every vector select statically sized.
    always_comb begin
        sel_found = 1'b0;
        sel_oh    = '0;
        sel_idx   = '0;
        sel_mac   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NETH; i++) begin
            cand = 32'(last_q) + i;
            if (cand >= NETH) begin
                cand = cand - NETH;
            end
            for (int unsigned k = 0; k < NETH; k++) begin
                if (!sel_found && (cand == k) && S_VALID[k]) begin
                    sel_found  = 1'b1;
                    sel_oh[k]  = 1'b1;
                    sel_idx    = LW'(k);
                    sel_mac    = S_DSTMAC[k*MACW +: MACW];
                end
            end
        end
    end

    assign resp_done = |(RESP_READY & grant_q);

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        mac_d    = mac_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    grant_d = sel_oh;
                    mac_d   = sel_mac;
                    last_d  = sel_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (TBL_READY) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                result_d = OPT_NOSELF ? (TBL_PORT & ~grant_q) : TBL_PORT;
                state_d  = RESP;
            end
            RESP: begin
                if (resp_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= LW'(NETH - 1);
            mac_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            mac_q    <= mac_d;
            result_q <= result_d;
        end
    end

    // Outputs are forced to their reset values while i_reset is high, not
    // only from the cycle after reset is sampled.
    assign tbl_active  = !i_reset && (state_q == ISSUE);
    assign resp_active = !i_reset && (state_q == RESP);

    assign S_READY    = (!i_reset && (state_q == IDLE)) ? sel_oh : '0;
    assign TBL_VALID  = tbl_active;
    assign TBL_DSTMAC = (i_reset || (OPT_LOWPOWER && !tbl_active)) ? '0 : mac_q;
    assign RESP_VALID = resp_active ? grant_q : '0;
    assign RESP_PORT  = (i_reset || (OPT_LOWPOWER && !resp_active)) ? '0 : result_q;

endmodule

// File: tb/tb_routelookup_arb.sv
// tb_routelookup_arb
//   Directed bench for routelookup_arb (NETH=4, MACW=48, OPT_NOSELF=1).
//   Inputs change just after the falling edge. Outputs are checked 1 time unit
//   later, well away from the rising edge.
module tb_routelookup_arb;

    logic         clk;
    logic         rst;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [191:0] s_dstmac;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [3:0]   resp_port;
    logic         tbl_valid;
    logic         tbl_ready;
    logic [47:0]  tbl_dstmac;
    logic [3:0]   tbl_port;

    logic [47:0]  macs [4];
    int           checks;
    int           errors;

    routelookup_arb #(
        .NETH        (4),
        .MACW        (48),
        .OPT_NOSELF  (1'b1),
        .OPT_LOWPOWER(1'b0)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .S_VALID   (s_valid),
        .S_READY   (s_ready),
        .S_DSTMAC  (s_dstmac),
        .RESP_VALID(resp_valid),
        .RESP_READY(resp_ready),
        .RESP_PORT (resp_port),
        .TBL_VALID (tbl_valid),
        .TBL_READY (tbl_ready),
        .TBL_DSTMAC(tbl_dstmac),
        .TBL_PORT  (tbl_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete lookup. The task starts in an IDLE cycle and returns at the
    // first IDLE cycle after the response handshake. A stall of zero gives
    // the unstalled timing: accept t, ISSUE t+1, WAIT t+2, RESP t+3.
    task automatic lookup(input string tag, input logic [3:0] sv, input int g,
                          input logic [3:0] tport, input logic [3:0] eport,
                          input int tstall, input int rstall);
        logic [3:0] oh;
        oh         = 4'b0001 << g;
        s_valid    = sv;
        tbl_ready  = 1'b0;
        resp_ready = 4'b0000;
        tbl_port   = ~tport;
        #1;
        chk({tag, ".accept"}, 64'(s_ready), 64'(oh));
        chk({tag, ".idle_tv"}, 64'(tbl_valid), 64'd0);
        @(negedge clk);
        for (int i = 0; i <= tstall; i++) begin
            tbl_ready = (i == tstall);
            #1;
            chk({tag, ".issue_tv"}, 64'(tbl_valid), 64'd1);
            chk({tag, ".issue_mac"}, 64'(tbl_dstmac), 64'(macs[g]));
            chk({tag, ".issue_sr"}, 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        tbl_ready = 1'b0;
        tbl_port  = tport;
        #1;
        chk({tag, ".wait_tv"}, 64'(tbl_valid), 64'd0);
        chk({tag, ".wait_rv"}, 64'(resp_valid), 64'd0);
        chk({tag, ".wait_sr"}, 64'(s_ready), 64'd0);
        @(negedge clk);
        tbl_port = ~tport;
        for (int i = 0; i <= rstall; i++) begin
            resp_ready = (i == rstall) ? 4'hF : ~oh;
            #1;
            chk({tag, ".resp_rv"}, 64'(resp_valid), 64'(oh));
            chk({tag, ".resp_port"}, 64'(resp_port), 64'(eport));
            chk({tag, ".resp_sr"}, 64'(s_ready), 64'd0);
            @(negedge clk);
        end
        resp_ready = 4'b0000;
    endtask

    initial begin
        int         order [5];
        logic [3:0] oh;
        checks = 0;
        errors = 0;
        macs[0] = 48'h020000000005;
        macs[1] = 48'hA00000000001;
        macs[2] = 48'hA00000000002;
        macs[3] = 48'hA00000000003;
        s_dstmac   = {macs[3], macs[2], macs[1], macs[0]};
        rst        = 1'b1;
        s_valid    = 4'hF;
        resp_ready = 4'h0;
        tbl_ready  = 1'b0;
        tbl_port   = 4'h0;

        // Reset state, with requests already pending.
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst.sready", 64'(s_ready), 64'd0);
        chk("rst.tvalid", 64'(tbl_valid), 64'd0);
        chk("rst.rvalid", 64'(resp_valid), 64'd0);
        chk("rst.tmac", 64'(tbl_dstmac), 64'd0);
        chk("rst.rport", 64'(resp_port), 64'd0);
        rst     = 1'b0;
        s_valid = 4'h0;
        @(negedge clk);
        #1;
        chk("idle.noreq", 64'(s_ready), 64'd0);
        @(negedge clk);

        // Single request: requester 0 gets 0110, and its own bit is already clear.
        lookup("single", 4'b0001, 0, 4'b0110, 4'b0110, 0, 0);
        // Self-mask: broadcast minus own port. Then a mask that goes to zero (drop).
        lookup("self2", 4'b0100, 2, 4'b1111, 4'b1011, 0, 0);
        lookup("self1", 4'b0010, 1, 4'b0010, 4'b0000, 0, 0);
        // Table stall: the last grant was 1, so the search from 2 picks 3 ahead of 0.
        lookup("tstall", 4'b1001, 3, 4'b0101, 4'b0101, 5, 0);
        // Response backpressure with all requesters waiting. The wrap gives 0, then 1.
        lookup("rstall", 4'b1111, 0, 4'b1001, 4'b1000, 0, 3);
        lookup("after", 4'b1111, 1, 4'b1111, 4'b1101, 0, 0);

        // Reset in WAIT. The last grant was 2, so without reset the next grant would be 3.
        s_valid   = 4'b0100;
        tbl_ready = 1'b1;
        #1;
        chk("rw.accept", 64'(s_ready), 64'b0100);
        @(negedge clk);
        s_valid = 4'b0000;
        #1;
        chk("rw.issue", 64'(tbl_valid), 64'd1);
        @(negedge clk);
        rst      = 1'b1;
        tbl_port = 4'hF;
        #1;
        chk("rw.sready", 64'(s_ready), 64'd0);
        chk("rw.tvalid", 64'(tbl_valid), 64'd0);
        chk("rw.rvalid", 64'(resp_valid), 64'd0);
        chk("rw.tmac", 64'(tbl_dstmac), 64'd0);
        chk("rw.rport", 64'(resp_port), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        tbl_ready = 1'b0;
        #1;
        chk("rw.post_rv", 64'(resp_valid), 64'd0);
        chk("rw.post_tv", 64'(tbl_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rw.quiet_rv", 64'(resp_valid), 64'd0);
        end
        @(negedge clk);

        // Round-robin from reset priority with everyone requesting.
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) begin
            oh = 4'b0001 << order[i];
            lookup("rr", 4'hF, order[i], 4'hF, 4'hF & ~oh, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
